// File: rtl/fq_enqueue.sv
// Header-steered packet enqueue: routes each packet from a single 64-bit stream
// into one of N per-channel FIFOs, discarding packets for disabled channels.
module fq_enqueue #(
    parameter int NUM_IN_LOG2 = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [63:0]            in_data,
    output logic                   in_ready,
    input  logic [2**NUM_IN_LOG2-1:0] chan_en,
    input  logic                   fifo_full  [0:2**NUM_IN_LOG2-1],
    output logic                   fifo_wrreq [0:2**NUM_IN_LOG2-1],
    output logic [63:0]            fifo_data  [0:2**NUM_IN_LOG2-1],
    output logic                   pkt_done,
    output logic [NUM_IN_LOG2-1:0] pkt_done_chan,
    output logic [15:0]            drop_count,
    output logic                   busy
);

    localparam int N = 2**NUM_IN_LOG2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t                 state_r, state_next_s;
    logic [7:0]             rem_r, rem_next_s;
    logic [NUM_IN_LOG2-1:0] cur_r, cur_next_s;
    logic [15:0]            drop_count_r;
    logic                   pkt_done_r;
    logic [NUM_IN_LOG2-1:0] pkt_done_chan_r;

    logic [7:0]             hdr_len_s;
    logic [NUM_IN_LOG2-1:0] hdr_ch_s;
    logic                   ready_s;
    logic                   write_s;
    logic [NUM_IN_LOG2-1:0] target_s;
    logic                   accept_s;
    logic                   drop_inc_s;
    logic                   done_s;
    logic [NUM_IN_LOG2-1:0] done_chan_s;

    assign hdr_len_s = in_data[7:0];
    assign hdr_ch_s  = in_data[8 +: NUM_IN_LOG2];

    // Readiness and write target; in IDLE this comes straight from header decode
    always_comb begin
        ready_s  = 1'b0;
        write_s  = 1'b0;
        target_s = cur_r;
        case (state_r)
            IDLE: begin
                target_s = hdr_ch_s;
                if (hdr_len_s == 8'd0) begin
                    ready_s = 1'b1;
                end else if (!chan_en[hdr_ch_s]) begin
                    ready_s = 1'b1;
                end else begin
                    ready_s = !fifo_full[hdr_ch_s];
                    write_s = 1'b1;
                end
            end
            FWD: begin
                ready_s = !fifo_full[cur_r];
                write_s = 1'b1;
            end
            DROP: begin
                ready_s = 1'b1;
            end
            default: begin
                ready_s = 1'b0;
            end
        endcase
    end

    assign in_ready = ready_s & ~rst;
    assign accept_s = in_valid & in_ready;

    // Zero-latency write strobes; data is broadcast to every channel
    always_comb begin
        for (int k = 0; k < N; k++) begin
            fifo_wrreq[k] = accept_s && write_s && (target_s == NUM_IN_LOG2'(k));
            fifo_data[k]  = in_data;
        end
    end

    // Next-state, counters and completion on each accepted word
    always_comb begin
        state_next_s = state_r;
        rem_next_s   = rem_r;
        cur_next_s   = cur_r;
        drop_inc_s   = 1'b0;
        done_s       = 1'b0;
        done_chan_s  = cur_r;
        if (accept_s) begin
            case (state_r)
                IDLE: begin
                    if (hdr_len_s == 8'd0) begin
                        drop_inc_s = 1'b1;
                    end else if (!chan_en[hdr_ch_s]) begin
                        drop_inc_s = 1'b1;
                        if (hdr_len_s != 8'd1) begin
                            state_next_s = DROP;
                            rem_next_s   = hdr_len_s - 8'd1;
                        end else begin
                            state_next_s = IDLE;
                        end
                    end else begin
                        cur_next_s = hdr_ch_s;
                        if (hdr_len_s == 8'd1) begin
                            done_s      = 1'b1;
                            done_chan_s = hdr_ch_s;
                        end else begin
                            state_next_s = FWD;
                            rem_next_s   = hdr_len_s - 8'd1;
                        end
                    end
                end
                FWD: begin
                    rem_next_s = rem_r - 8'd1;
                    if (rem_r == 8'd1) begin
                        state_next_s = IDLE;
                        done_s       = 1'b1;
                        done_chan_s  = cur_r;
                    end else begin
                        state_next_s = FWD;
                    end
                end
                DROP: begin
                    rem_next_s = rem_r - 8'd1;
                    if (rem_r == 8'd1) begin
                        state_next_s = IDLE;
                    end else begin
                        state_next_s = DROP;
                    end
                end
                default: begin
                    state_next_s = IDLE;
                end
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= IDLE;
            rem_r           <= 8'd0;
            cur_r           <= {NUM_IN_LOG2{1'b0}};
            drop_count_r    <= 16'd0;
            pkt_done_r      <= 1'b0;
            pkt_done_chan_r <= {NUM_IN_LOG2{1'b0}};
        end else begin
            state_r    <= state_next_s;
            rem_r      <= rem_next_s;
            cur_r      <= cur_next_s;
            pkt_done_r <= done_s;
            if (done_s) begin
                pkt_done_chan_r <= done_chan_s;
            end
            if (drop_inc_s && (drop_count_r != 16'hFFFF)) begin
                drop_count_r <= drop_count_r + 16'd1;
            end
        end
    end

    assign pkt_done      = pkt_done_r;
    assign pkt_done_chan = pkt_done_chan_r;
    assign drop_count    = drop_count_r;
    assign busy          = (state_r != IDLE);

endmodule

// File: tb/tb_fq_enqueue.sv
// Directed self-checking bench for fq_enqueue with N = 8 channels.
module tb_fq_enqueue;

    localparam int L2 = 3;
    localparam int N  = 8;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic [63:0]   in_data;
    logic          in_ready;
    logic [N-1:0]  chan_en;
    logic          fifo_full  [0:N-1];
    logic          fifo_wrreq [0:N-1];
    logic [63:0]   fifo_data  [0:N-1];
    logic          pkt_done;
    logic [L2-1:0] pkt_done_chan;
    logic [15:0]   drop_count;
    logic          busy;

    int errors = 0;
    int checks = 0;
    int wr_count = 0;
    int wr_base;

    fq_enqueue #(.NUM_IN_LOG2(L2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .chan_en(chan_en), .fifo_full(fifo_full),
        .fifo_wrreq(fifo_wrreq), .fifo_data(fifo_data), .pkt_done(pkt_done),
        .pkt_done_chan(pkt_done_chan), .drop_count(drop_count), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N-1:0] wr_vec();
        logic [N-1:0] v;
        for (int k = 0; k < N; k++) v[k] = fifo_wrreq[k];
        return v;
    endfunction

    // Counts every write strobe seen at a clock edge
    always @(posedge clk) begin
        if (|wr_vec()) wr_count <= wr_count + 1;
    end

    function automatic logic [63:0] hdr(int len, int ch);
        logic [63:0] w;
        w = 64'hC0DE_0000_0000_0000;
        w[7:0]  = len[7:0];
        w[10:8] = ch[2:0];
        return w;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [63:0] d);
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = 64'd0;
        chan_en = 8'hFF;
        for (int k = 0; k < N; k++) fifo_full[k] = 1'b0;

        // Reset: no ready, no writes, registers cleared
        drive(1'b1, hdr(3, 5));
        chk("rst_ready", in_ready, 1'b0);
        chk("rst_wr", wr_vec(), 8'h00);
        tick();
        tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_drop", drop_count, 16'd0);
        chk("rst_done", pkt_done, 1'b0);
        chk("rst_done_chan", pkt_done_chan, 3'd0);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;

        // Forward L=3 to ch 5
        wr_base = wr_count;
        drive(1'b1, hdr(3, 5));
        chk("fwd_ready", in_ready, 1'b1);
        chk("fwd_wr0", wr_vec(), 8'h20);
        chk("fwd_data0", fifo_data[5], hdr(3, 5));
        tick();
        chk("fwd_busy", busy, 1'b1);
        chk("fwd_nodone0", pkt_done, 1'b0);
        drive(1'b0, 64'h1111_2222_3333_4444);
        chk("fwd_ready_novalid", in_ready, 1'b1);
        chk("fwd_wr_novalid", wr_vec(), 8'h00);
        tick();
        drive(1'b1, 64'h1111_2222_3333_4444);
        chk("fwd_wr1", wr_vec(), 8'h20);
        chk("fwd_data1", fifo_data[5], 64'h1111_2222_3333_4444);
        tick();
        chk("fwd_nodone1", pkt_done, 1'b0);
        drive(1'b1, 64'h5555_6666_7777_8888);
        chk("fwd_wr2", wr_vec(), 8'h20);
        chk("fwd_data2", fifo_data[5], 64'h5555_6666_7777_8888);
        tick();
        chk("fwd_done", pkt_done, 1'b1);
        chk("fwd_done_chan", pkt_done_chan, 3'd5);
        chk("fwd_writes", wr_count - wr_base, 3);
        drive(1'b0, 64'd0);
        chk("fwd_idle_wr", wr_vec(), 8'h00);
        tick();
        chk("fwd_done_pulse", pkt_done, 1'b0);
        chk("fwd_busy_after", busy, 1'b0);

        // Backpressure L=4 to ch 2
        wr_base = wr_count;
        drive(1'b1, hdr(4, 2));
        chk("bp_wr0", wr_vec(), 8'h04);
        tick();
        drive(1'b1, 64'hAAAA_0000_0000_0001);
        chk("bp_wr1", wr_vec(), 8'h04);
        chk("bp_data1", fifo_data[2], 64'hAAAA_0000_0000_0001);
        tick();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            fifo_full[2] = 1'b1;
            in_valid = 1'b1;
            in_data = 64'hAAAA_0000_0000_0002;
            #1;
            chk("bp_full_ready", in_ready, 1'b0);
            chk("bp_full_wr", wr_vec(), 8'h00);
            tick();
            chk("bp_full_busy", busy, 1'b1);
        end
        @(negedge clk);
        fifo_full[2] = 1'b0;
        #1;
        chk("bp_wr2", wr_vec(), 8'h04);
        chk("bp_data2", fifo_data[2], 64'hAAAA_0000_0000_0002);
        tick();
        drive(1'b1, 64'hAAAA_0000_0000_0003);
        chk("bp_wr3", wr_vec(), 8'h04);
        chk("bp_data3", fifo_data[2], 64'hAAAA_0000_0000_0003);
        tick();
        chk("bp_done", pkt_done, 1'b1);
        chk("bp_done_chan", pkt_done_chan, 3'd2);
        chk("bp_writes", wr_count - wr_base, 4);
        chk("bp_busy_after", busy, 1'b0);

        // Drops: L=0 header, then L=3 to disabled ch 1
        wr_base = wr_count;
        drive(1'b1, hdr(0, 3));
        chk("drop0_ready", in_ready, 1'b1);
        chk("drop0_wr", wr_vec(), 8'h00);
        tick();
        chk("drop0_busy", busy, 1'b0);
        chk("drop0_cnt", drop_count, 16'd1);
        chan_en = 8'hFD;
        drive(1'b1, hdr(3, 1));
        chk("dropd_ready", in_ready, 1'b1);
        chk("dropd_wr", wr_vec(), 8'h00);
        tick();
        chk("dropd_busy", busy, 1'b1);
        chk("dropd_cnt", drop_count, 16'd2);
        fifo_full[1] = 1'b1;
        drive(1'b1, 64'hDEAD_0000_0000_0001);
        chk("dropb_ready", in_ready, 1'b1);
        tick();
        fifo_full[1] = 1'b0;
        drive(1'b1, 64'hDEAD_0000_0000_0002);
        tick();
        chk("dropb_busy", busy, 1'b0);
        chk("dropb_nodone", pkt_done, 1'b0);
        chk("dropb_cnt", drop_count, 16'd2);
        chk("drop_writes", wr_count - wr_base, 0);
        chan_en = 8'hFF;

        // Single-word packet, then next word is a header
        drive(1'b1, hdr(1, 0));
        chk("single_wr", wr_vec(), 8'h01);
        tick();
        chk("single_busy", busy, 1'b0);
        chk("single_done", pkt_done, 1'b1);
        chk("single_done_chan", pkt_done_chan, 3'd0);
        drive(1'b1, hdr(2, 6));
        chk("next_hdr_wr", wr_vec(), 8'h40);
        tick();
        chk("next_hdr_nodone", pkt_done, 1'b0);
        chk("next_hdr_busy", busy, 1'b1);
        chan_en = 8'h00;
        drive(1'b1, 64'h7777_0000_0000_0000);
        chk("chan_en_mid_wr", wr_vec(), 8'h40);
        tick();
        chk("next_done", pkt_done, 1'b1);
        chk("next_done_chan", pkt_done_chan, 3'd6);
        chan_en = 8'hFF;

        // Saturation: 65537 empty headers
        drive(1'b1, hdr(0, 0));
        repeat (65537) @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("sat_cnt", drop_count, 16'hFFFF);
        drive(1'b1, hdr(0, 0));
        tick();
        chk("sat_hold", drop_count, 16'hFFFF);

        // Reset in the middle of an L=5 packet
        drive(1'b1, hdr(5, 3));
        tick();
        drive(1'b1, 64'hBEEF_0000_0000_0001);
        tick();
        chk("mid_busy", busy, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        in_data = 64'hBEEF_0000_0000_0002;
        #1;
        chk("mid_rst_ready", in_ready, 1'b0);
        chk("mid_rst_wr", wr_vec(), 8'h00);
        tick();
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_cnt", drop_count, 16'd0);
        chk("mid_rst_done", pkt_done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        in_data = hdr(1, 4);
        #1;
        chk("post_rst_hdr_wr", wr_vec(), 8'h10);
        tick();
        chk("post_rst_done", pkt_done, 1'b1);
        chk("post_rst_done_chan", pkt_done_chan, 3'd4);
        chk("post_rst_busy", busy, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fq_enqueue.md
FQ_ENQUEUE -- requirements
Module: fq_enqueue

Interface
REQ-001 SHALL have parameter NUM_IN_LOG2, default 3, log2 of channel count N = 2**NUM_IN_LOG2.
REQ-002 SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 in_valid  input  1  upstream word present.
REQ-006 in_data  input  64  upstream word.
REQ-007 in_ready  output  1  word accepted when in_valid && in_ready at a clock edge.
REQ-008 chan_en  input  N  per-channel enable; packets to a disabled channel are discarded.
REQ-009 fifo_full  input  1 x N (unpacked)  per-channel FIFO full.
REQ-010 fifo_wrreq  output  1 x N (unpacked)  per-channel FIFO write strobe.
REQ-011 fifo_data  output  64 x N (unpacked)  per-channel FIFO write data.
REQ-012 pkt_done  output  1  one-cycle pulse after a packet's last word is written.
REQ-013 pkt_done_chan  output  NUM_IN_LOG2  channel of the packet flagged by pkt_done.
REQ-014 drop_count  output  16  number of dropped packets, saturating.
REQ-015 busy  output  1  high when state is not IDLE.

Function
REQ-016 Header word format SHALL be: L = in_data[7:0], the packet length in words including the header; ch = in_data[8 +: NUM_IN_LOG2].
REQ-017 FSM SHALL have states IDLE (expect header), FWD (write body to channel cur), and DROP (discard body); it SHALL hold an 8-bit remaining-word counter rem and a channel register cur.
REQ-018 In IDLE with L==0, the block SHALL assert in_ready=1; on accept it SHALL perform no write, increment drop_count, and stay in IDLE.
REQ-019 In IDLE with L!=0 and chan_en[ch]==0, the block SHALL assert in_ready=1 and perform no write; on accept it SHALL increment drop_count and go to IDLE if L==1, else go to DROP with rem=L-1.
REQ-020 In IDLE with L!=0 and chan_en[ch]==1, the block SHALL assert in_ready=!fifo_full[ch]; on accept it SHALL write the header to ch and set cur=ch; if L==1 it SHALL stay in IDLE and pulse pkt_done, else go to FWD with rem=L-1.
REQ-021 In FWD, the block SHALL assert in_ready=!fifo_full[cur]; each accept SHALL write the word to cur and decrement rem; an accept with rem==1 SHALL go to IDLE and pulse pkt_done.
REQ-022 In DROP, the block SHALL assert in_ready=1; each accept SHALL decrement rem with no write; an accept with rem==1 SHALL go to IDLE with no pkt_done.
REQ-023 Write path SHALL be combinational with zero latency: fifo_wrreq[k] = accept && writing && target==k; fifo_data[k] = in_data for all k.
REQ-024 At most one fifo_wrreq bit SHALL be high in any cycle, and never while fifo_full of that channel is high.
REQ-025 pkt_done and pkt_done_chan SHALL be registered and assert in the cycle after the last word is accepted, for exactly one cycle.
REQ-026 in_ready SHALL depend only on state, cur, rem, fifo_full, chan_en and in_data (header decode), and never on in_valid.
REQ-027 chan_en SHALL be sampled only at header acceptance; changes mid-packet SHALL NOT affect the packet.
REQ-028 drop_count SHALL saturate at 16'hFFFF.
REQ-029 in_valid low SHALL leave all state unchanged, including mid-packet.

Reset
REQ-030 On rst, state SHALL be IDLE; rem, cur, drop_count, pkt_done and pkt_done_chan SHALL be 0.
REQ-031 During rst, fifo_wrreq SHALL be all 0 and in_ready SHALL be 0.
REQ-032 Reset mid-packet SHALL abandon the packet without a pkt_done pulse; the next accepted word SHALL be treated as a header.

Verification
REQ-033 Forward: header L=3, ch=5, all enabled and not full, three back-to-back words -> fifo_wrreq[5] high 3 cycles, data matches, pkt_done=1 with pkt_done_chan=5 one cycle after the third word, busy low afterwards.
REQ-034 Backpressure: L=4 to ch=2 with fifo_full[2] raised for 2 cycles mid-packet -> in_ready=0 and no write during those cycles; all 4 words are written in order with none lost or duplicated.
REQ-035 Drops: header L=0, then header L=3 to disabled ch=1 -> 4 words accepted, 0 writes, drop_count=2, no pkt_done.
REQ-036 Single-word packet: L=1, ch=0 -> one write, pkt_done, stays in IDLE; next word is decoded as a header.
REQ-037 Saturation and reset: 65537 L=0 headers -> drop_count=16'hFFFF; rst in the middle of an L=5 packet -> busy=0, counters 0, no pkt_done.
